// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Encodes an RV32I mnemonic request (op_sel plus register and immediate fields)
// into a 32-bit machine word. Each word is tagged with a byte address that
// starts at BASE_ADDR after reset and advances by 4 for each emitted word.
// The output side is a one-entry register with a valid/ready handshake.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   request present
//   in_ready   out  request accepted this cycle (!out_valid || out_ready)
//   op_sel     in   [5:0]  mnemonic index 0..36 (add .. auipc)
//   rd/rs1/rs2 in   [4:0]  register fields
//   imm        in   [31:0] immediate in byte units
//   out_valid  out  out_instr/out_addr hold a word
//   out_ready  in   consumer takes the word
//   out_instr  out  [31:0] machine word
//   out_addr   out  [31:0] byte address of out_instr
//   err_pulse  out  one-cycle flag after a rejected request
//   err_sticky out  latched error flag, cleared only by reset
//
// Build option
//   ENC_RANGE_CHECK_EN : when defined, requests whose immediate does not fit
//   the instruction format are rejected like an unknown op_sel. When not
//   defined, immediates are silently truncated into the format.
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  op_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_pulse,
  output logic        err_sticky
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ALT = 7'h20;
  localparam logic [6:0] F7_STD = 7'h00;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] next_addr_r;
  logic        accept_s;
  logic        legal_s;
  logic        load_s;
  logic        out_xfer_s;
  logic [31:0] enc_word_s;

  // Map a request onto its RV32I machine word; unknown op_sel yields zero.
  function automatic logic [31:0] encode(
    input logic [5:0]  op,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_rs1,
    input logic [4:0]  f_rs2,
    input logic [31:0] f_imm
  );
    logic [31:0] w;
    w = 32'h0000_0000;
    case (op)
      6'd0:  w = {F7_STD, f_rs2, f_rs1, 3'd0, f_rd, OPC_R};  // add
      6'd1:  w = {F7_ALT, f_rs2, f_rs1, 3'd0, f_rd, OPC_R};  // sub
      6'd2:  w = {F7_STD, f_rs2, f_rs1, 3'd4, f_rd, OPC_R};  // xor
      6'd3:  w = {F7_STD, f_rs2, f_rs1, 3'd6, f_rd, OPC_R};  // or
      6'd4:  w = {F7_STD, f_rs2, f_rs1, 3'd7, f_rd, OPC_R};  // and
      6'd5:  w = {F7_STD, f_rs2, f_rs1, 3'd1, f_rd, OPC_R};  // sll
      6'd6:  w = {F7_STD, f_rs2, f_rs1, 3'd5, f_rd, OPC_R};  // srl
      6'd7:  w = {F7_ALT, f_rs2, f_rs1, 3'd5, f_rd, OPC_R};  // sra
      6'd8:  w = {F7_STD, f_rs2, f_rs1, 3'd2, f_rd, OPC_R};  // slt
      6'd9:  w = {F7_STD, f_rs2, f_rs1, 3'd3, f_rd, OPC_R};  // sltu
      6'd10: w = {f_imm[11:0], f_rs1, 3'd0, f_rd, OPC_I};    // addi
      6'd11: w = {f_imm[11:0], f_rs1, 3'd4, f_rd, OPC_I};    // xori
      6'd12: w = {f_imm[11:0], f_rs1, 3'd6, f_rd, OPC_I};    // ori
      6'd13: w = {f_imm[11:0], f_rs1, 3'd7, f_rd, OPC_I};    // andi
      6'd14: w = {F7_STD, f_imm[4:0], f_rs1, 3'd1, f_rd, OPC_I};  // slli
      6'd15: w = {F7_STD, f_imm[4:0], f_rs1, 3'd5, f_rd, OPC_I};  // srli
      6'd16: w = {F7_ALT, f_imm[4:0], f_rs1, 3'd5, f_rd, OPC_I};  // srai
      6'd17: w = {f_imm[11:0], f_rs1, 3'd2, f_rd, OPC_I};    // slti
      6'd18: w = {f_imm[11:0], f_rs1, 3'd3, f_rd, OPC_I};    // sltiu
      6'd19: w = {f_imm[11:0], f_rs1, 3'd0, f_rd, OPC_LOAD}; // lb
      6'd20: w = {f_imm[11:0], f_rs1, 3'd1, f_rd, OPC_LOAD}; // lh
      6'd21: w = {f_imm[11:0], f_rs1, 3'd2, f_rd, OPC_LOAD}; // lw
      6'd22: w = {f_imm[11:0], f_rs1, 3'd4, f_rd, OPC_LOAD}; // lbu
      6'd23: w = {f_imm[11:0], f_rs1, 3'd5, f_rd, OPC_LOAD}; // lhu
      6'd24: w = {f_imm[11:5], f_rs2, f_rs1, 3'd0, f_imm[4:0], OPC_STORE};  // sb
      6'd25: w = {f_imm[11:5], f_rs2, f_rs1, 3'd1, f_imm[4:0], OPC_STORE};  // sh
      6'd26: w = {f_imm[11:5], f_rs2, f_rs1, 3'd2, f_imm[4:0], OPC_STORE};  // sw
      6'd27: w = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, 3'd0, f_imm[4:1], f_imm[11], OPC_BRANCH};
      6'd28: w = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, 3'd1, f_imm[4:1], f_imm[11], OPC_BRANCH};
      6'd29: w = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, 3'd4, f_imm[4:1], f_imm[11], OPC_BRANCH};
      6'd30: w = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, 3'd5, f_imm[4:1], f_imm[11], OPC_BRANCH};
      6'd31: w = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, 3'd6, f_imm[4:1], f_imm[11], OPC_BRANCH};
      6'd32: w = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, 3'd7, f_imm[4:1], f_imm[11], OPC_BRANCH};
      6'd33: w = {f_imm[20], f_imm[10:1], f_imm[11], f_imm[19:12], f_rd, OPC_JAL};
      6'd34: w = {f_imm[11:0], f_rs1, 3'd0, f_rd, OPC_JALR};
      6'd35: w = {f_imm[31:12], f_rd, OPC_LUI};
      6'd36: w = {f_imm[31:12], f_rd, OPC_AUIPC};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

`ifdef ENC_RANGE_CHECK_EN
  // True when the immediate fits the format selected by op without loss.
  function automatic logic imm_fits(input logic [5:0] op, input logic [31:0] f_imm);
    logic ok;
    logic signed [31:0] s;
    s  = $signed(f_imm);
    ok = 1'b1;
    if ((op >= 6'd10 && op <= 6'd13) || (op >= 6'd17 && op <= 6'd26) || (op == 6'd34)) begin
      ok = (s >= -32'sd2048) && (s <= 32'sd2047);
    end else if (op >= 6'd14 && op <= 6'd16) begin
      ok = (f_imm[31:5] == 27'd0);
    end else if (op >= 6'd27 && op <= 6'd32) begin
      ok = (s >= -32'sd4096) && (s <= 32'sd4094) && (f_imm[0] == 1'b0);
    end else if (op == 6'd33) begin
      ok = (s >= -32'sd1048576) && (s <= 32'sd1048574) && (f_imm[0] == 1'b0);
    end else if (op == 6'd35 || op == 6'd36) begin
      ok = (f_imm[11:0] == 12'd0);
    end else begin
      ok = 1'b1;  // R-type has no immediate
    end
    return ok;
  endfunction
`endif

  // Handshake and legality decode.
  always_comb begin
    out_valid  = (state_r == FULL) && !rst;
    in_ready   = !rst && (!out_valid || out_ready);
    accept_s   = in_valid && in_ready;
    out_xfer_s = out_valid && out_ready;
`ifdef ENC_RANGE_CHECK_EN
    legal_s    = (op_sel <= 6'd36) && imm_fits(op_sel, imm);
`else
    legal_s    = (op_sel <= 6'd36);
`endif
    load_s     = accept_s && legal_s;
    enc_word_s = encode(op_sel, rd, rs1, rs2, imm);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: a legal accept fills, a transfer without refill drains.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (load_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer_s && !load_s) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = FULL;
        end
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // Output word, address counter and error flags. The address counter moves
  // when a word is loaded; every loaded word is later transferred (reset also
  // rewinds the counter), so this equals advancing once per output transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_instr   <= 32'h0000_0000;
      out_addr    <= BASE_ADDR;
      next_addr_r <= BASE_ADDR;
      err_pulse   <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      if (load_s) begin
        out_instr   <= enc_word_s;
        out_addr    <= next_addr_r;
        next_addr_r <= next_addr_r + 32'd4;
      end else begin
        out_instr   <= out_instr;
        out_addr    <= out_addr;
        next_addr_r <= next_addr_r;
      end
      err_pulse <= accept_s && !legal_s;
      if (accept_s && !legal_s) begin
        err_sticky <= 1'b1;
      end else begin
        err_sticky <= err_sticky;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed self-checking bench for instr_encoder: reset state, encodings of
// each format, back-to-back throughput with address sequencing, output stall,
// rejected requests, immediate truncation/range handling and mid-run reset.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op_sel;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_pulse;
  logic        err_sticky;

  int checks;
  int failures;

  instr_encoder #(.BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_sel     (op_sel),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    in_valid = 1'b1;
    op_sel   = op;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    imm      = im;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
  endtask

  // Back-to-back sequence: op, rd, rs1, rs2, imm, expected word.
  typedef struct {
    logic [5:0]  op;
    logic [4:0]  d;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] im;
    logic [31:0] word;
  } vec_t;

  vec_t seq [11];

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_sel    = 6'd0;
    rd        = 5'd0;
    rs1       = 5'd0;
    rs2       = 5'd0;
    imm       = 32'd0;

    seq[0]  = '{6'd10, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093};  // addi x1,x0,-1
    seq[1]  = '{6'd27, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE20_8CE3};  // beq x1,x2,-8
    seq[2]  = '{6'd33, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF};  // jal x1,2048
    seq[3]  = '{6'd35, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7};  // lui x5
    seq[4]  = '{6'd1,  5'd1, 5'd2, 5'd3, 32'h0000_0000, 32'h4031_00B3};  // sub
    seq[5]  = '{6'd16, 5'd4, 5'd5, 5'd0, 32'h0000_0003, 32'h4032_D213};  // srai
    seq[6]  = '{6'd23, 5'd6, 5'd7, 5'd0, 32'h0000_0010, 32'h0103_D303};  // lhu
    seq[7]  = '{6'd26, 5'd0, 5'd2, 5'd3, 32'hFFFF_FFFC, 32'hFE31_2E23};  // sw
    seq[8]  = '{6'd34, 5'd1, 5'd2, 5'd0, 32'h0000_0004, 32'h0041_00E7};  // jalr
    seq[9]  = '{6'd36, 5'd7, 5'd0, 5'd0, 32'hABCD_E000, 32'hABCD_E397};  // auipc
    seq[10] = '{6'd32, 5'd0, 5'd1, 5'd2, 32'h0000_0010, 32'h0020_F863};  // bgeu

    // Reset state, observed while rst is still high.
    step();
    step();
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_instr", out_instr, 32'h0000_0000);
    check_eq("rst_out_addr", out_addr, 32'h0000_0000);
    check_eq("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    check_eq("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Single add, one-cycle latency at BASE_ADDR.
    drive(6'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    in_valid = 1'b0;
    check_eq("add_valid", {31'd0, out_valid}, 32'd1);
    check_eq("add_instr", out_instr, 32'h0020_81B3);
    check_eq("add_addr", out_addr, 32'h0000_0000);
    step();
    check_eq("add_drained", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream with the consumer always ready.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(seq[i].op, seq[i].d, seq[i].s1, seq[i].s2, seq[i].im);
      step();
      check_eq($sformatf("seq%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("seq%0d_instr", i), out_instr, seq[i].word);
      check_eq($sformatf("seq%0d_addr", i), out_addr, 32'(i * 4));
    end
    in_valid = 1'b0;
    step();
    check_eq("seq_drained", {31'd0, out_valid}, 32'd0);

    // Output stall: word held, next request waits, addresses stay contiguous.
    do_reset();
    out_ready = 1'b0;
    drive(6'd10, 5'd2, 5'd0, 5'd0, 32'd5);            // addi x2,x0,5
    step();
    drive(6'd11, 5'd3, 5'd2, 5'd0, 32'd1);            // xori x3,x2,1
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("stall%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      check_eq($sformatf("stall%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("stall%0d_instr", i), out_instr, 32'h0050_0113);
      check_eq($sformatf("stall%0d_addr", i), out_addr, 32'h0000_0000);
      step();
    end
    out_ready = 1'b1;
    #1;
    check_eq("release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check_eq("release_valid", {31'd0, out_valid}, 32'd1);
    check_eq("release_instr", out_instr, 32'h0011_4193);
    check_eq("release_addr", out_addr, 32'h0000_0004);
    step();
    check_eq("release_drained", {31'd0, out_valid}, 32'd0);

    // Unknown op_sel: error flags, no word, address not consumed.
    do_reset();
    drive(6'd40, 5'd1, 5'd1, 5'd1, 32'd0);
    step();
    in_valid = 1'b0;
    check_eq("err_pulse_hi", {31'd0, err_pulse}, 32'd1);
    check_eq("err_sticky_hi", {31'd0, err_sticky}, 32'd1);
    check_eq("err_no_word", {31'd0, out_valid}, 32'd0);
    step();
    check_eq("err_pulse_lo", {31'd0, err_pulse}, 32'd0);
    check_eq("err_sticky_held", {31'd0, err_sticky}, 32'd1);
    drive(6'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    check_eq("err_next_instr", out_instr, 32'h0020_81B3);
    check_eq("err_next_addr", out_addr, 32'h0000_0000);

    // Illegal request while a word is pending and being taken.
    drive(6'd63, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    check_eq("err2_pulse", {31'd0, err_pulse}, 32'd1);
    check_eq("err2_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    drive(6'd1, 5'd1, 5'd2, 5'd3, 32'd0);             // sub
    step();
    in_valid = 1'b0;
    check_eq("err2_next_instr", out_instr, 32'h4031_00B3);
    check_eq("err2_next_addr", out_addr, 32'h0000_0004);

    // Reset with a pending word and err_sticky set.
    rst = 1'b1;
    #1;
    check_eq("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    check_eq("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_mid_addr", out_addr, 32'h0000_0000);
    check_eq("rst_mid_sticky", {31'd0, err_sticky}, 32'd0);
    check_eq("rst_mid_instr", out_instr, 32'h0000_0000);

    // addi with an immediate one past the I-format range.
    drive(6'd10, 5'd1, 5'd0, 5'd0, 32'd2048);
    step();
    in_valid = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    check_eq("range_valid", {31'd0, out_valid}, 32'd0);
    check_eq("range_err", {31'd0, err_pulse}, 32'd1);
`else
    check_eq("range_valid", {31'd0, out_valid}, 32'd1);
    check_eq("range_instr", out_instr, 32'h8000_0093);
    check_eq("range_err", {31'd0, err_pulse}, 32'd0);
`endif
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
